// File: rtl/ldd_decode_pipe.sv
// ldd_decode_pipe: two-stage select/qualifier/priority decoder with valid/ready
// flow control and a saturating counter of consumed "none" results.
// Stage 1 registers the raw input word. Stage 2 registers the decoded result.
// Data registers load only on an actual transfer, so an idle pipe does not toggle.
module ldd_decode_pipe #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned PRI_W = 5,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned DEC_W = 2 ** (SEL_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             qual,
  input  logic [PRI_W-1:0] pri,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DEC_W-1:0] dec,
  output logic [PRI_W-1:0] pri_hit,
  output logic             none,
  output logic             any_hit,
  output logic [CNT_W-1:0] none_cnt,
  input  logic             cnt_clr
);

  // Stage-1 state
  logic             s1_valid_q, s1_valid_d;
  logic [SEL_W-1:0] s1_sel_q;
  logic             s1_qual_q;
  logic [PRI_W-1:0] s1_pri_q;

  // Stage-2 state
  logic             out_valid_q, out_valid_d;
  logic [DEC_W-1:0] dec_q;
  logic [PRI_W-1:0] pri_hit_q;
  logic             none_q;
  logic             any_hit_q;

  logic [CNT_W-1:0] none_cnt_q, none_cnt_d;

  // Handshake terms
  logic adv2;
  logic accept;
  logic load2;

  // Decode of the stage-1 word
  logic [SEL_W:0]   dec_idx;
  logic [DEC_W-1:0] dec_c;
  logic [PRI_W-1:0] pri_hit_c;
  logic             none_c;
  logic             any_hit_c;
  logic             sel_zero;

  // Flow control: stage 2 can take a word if empty or being drained this cycle
  always_comb begin
    adv2     = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || adv2;
    accept   = in_valid && in_ready;
    load2    = s1_valid_q && adv2;
  end

  // Valid-bit next state; a simultaneous capture and advance keeps s1 full
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end
    out_valid_d = out_valid_q;
    if (load2) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Select/priority decode; lowest set bit isolated by two's-complement trick
  always_comb begin
    dec_idx          = {s1_sel_q, s1_qual_q};
    dec_c            = '0;
    dec_c[dec_idx]   = 1'b1;
    sel_zero         = (s1_sel_q == '0);
    pri_hit_c        = '0;
    none_c           = 1'b0;
    if (sel_zero) begin
      pri_hit_c = s1_pri_q & (~s1_pri_q + PRI_W'(1));
      none_c    = (s1_pri_q == '0);
    end
    any_hit_c = |pri_hit_c;
  end

  // Saturating none counter; clear takes priority over increment
  always_comb begin
    none_cnt_d = none_cnt_q;
    if (cnt_clr) begin
      none_cnt_d = '0;
    end else if (out_valid_q && out_ready && none_q && (none_cnt_q != '1)) begin
      none_cnt_d = none_cnt_q + CNT_W'(1);
    end
  end

  // Valid bits and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      none_cnt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      none_cnt_q  <= none_cnt_d;
    end
  end

  // Stage-1 data registers, loaded only on an accepted input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sel_q  <= '0;
      s1_qual_q <= 1'b0;
      s1_pri_q  <= '0;
    end else if (accept) begin
      s1_sel_q  <= sel;
      s1_qual_q <= qual;
      s1_pri_q  <= pri;
    end
  end

  // Stage-2 result registers, loaded only when a word advances from stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q     <= '0;
      pri_hit_q <= '0;
      none_q    <= 1'b0;
      any_hit_q <= 1'b0;
    end else if (load2) begin
      dec_q     <= dec_c;
      pri_hit_q <= pri_hit_c;
      none_q    <= none_c;
      any_hit_q <= any_hit_c;
    end
  end

  assign out_valid = out_valid_q;
  assign dec       = dec_q;
  assign pri_hit   = pri_hit_q;
  assign none      = none_q;
  assign any_hit   = any_hit_q;
  assign none_cnt  = none_cnt_q;

endmodule

// File: tb/tb_ldd_decode_pipe.sv
// Directed self-checking bench for ldd_decode_pipe. A second instance with a
// 2-bit counter shares the inputs to exercise counter saturation.
module tb_ldd_decode_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  sel;
  logic        qual;
  logic [4:0]  pri;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dec;
  logic [4:0]  pri_hit;
  logic        none;
  logic        any_hit;
  logic [7:0]  none_cnt;
  logic        cnt_clr;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_dec;
  logic [4:0]  s_pri_hit;
  logic        s_none;
  logic        s_any_hit;
  logic [1:0]  s_none_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ldd_decode_pipe #(.SEL_W(3), .PRI_W(5), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .qual(qual), .pri(pri), .out_valid(out_valid), .out_ready(out_ready),
    .dec(dec), .pri_hit(pri_hit), .none(none), .any_hit(any_hit),
    .none_cnt(none_cnt), .cnt_clr(cnt_clr)
  );

  ldd_decode_pipe #(.SEL_W(3), .PRI_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .sel(sel), .qual(qual), .pri(pri), .out_valid(s_out_valid), .out_ready(out_ready),
    .dec(s_dec), .pri_hit(s_pri_hit), .none(s_none), .any_hit(s_any_hit),
    .none_cnt(s_none_cnt), .cnt_clr(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    sel       = '0;
    qual      = 1'b0;
    pri       = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    sel       = '0;
    qual      = 1'b0;
    pri       = '0;
    #1;
    n_tests++;
    if ({out_valid, dec, pri_hit, none, any_hit, none_cnt} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ov=%b dec=%h ph=%b none=%b any=%b cnt=%0d, expected all 0",
               out_valid, dec, pri_hit, none, any_hit, none_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel       = 3'd0;
    qual      = 1'b1;
    pri       = 5'b10100;
    step();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_valid: got %b, expected 0", out_valid);
    end
    step();
    n_tests++;
    if ({out_valid, dec, pri_hit, none, any_hit} !== {1'b1, 16'h0002, 5'b00100, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_result: got ov=%b dec=%h ph=%b none=%b any=%b, expected 1 0002 00100 0 1",
               out_valid, dec, pri_hit, none, any_hit);
    end
    step();
    n_tests++;
    if ({out_valid, dec, pri_hit, any_hit} !== {1'b0, 16'h0002, 5'b00100, 1'b1}) begin
      n_fail++;
      $display("FAIL single_hold_after_consume: got ov=%b dec=%h ph=%b any=%b, expected 0 0002 00100 1",
               out_valid, dec, pri_hit, any_hit);
    end
  endtask

  task automatic test_stream();
    logic [15:0] e_dec;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        in_valid = 1'b1;
        sel      = 3'(i);
        qual     = 1'(i & 1);
        pri      = 5'b00000;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        e_dec = 16'h0001 << (2 * (i - 1) + ((i - 1) & 1));
        n_tests++;
        if ({out_valid, dec, none, pri_hit, any_hit} !== {1'b1, e_dec, (i == 1), 5'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL stream_word%0d: got ov=%b dec=%h none=%b ph=%b any=%b, expected 1 %h %b 0 0",
                   i - 1, out_valid, dec, none, pri_hit, any_hit, e_dec, (i == 1));
        end
      end
    end
    step();
    n_tests++;
    if ({out_valid, none_cnt} !== {1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL stream_end: got ov=%b cnt=%0d, expected ov=0 cnt=1", out_valid, none_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    // W0: sel=2 qual=0 pri=00001
    in_valid = 1'b1; sel = 3'd2; qual = 1'b0; pri = 5'b00001;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_c0: got %b, expected 1", in_ready);
    end
    step();
    // W1: sel=0 qual=0 pri=01100
    sel = 3'd0; qual = 1'b0; pri = 5'b01100;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_c1: got %b, expected 1", in_ready);
    end
    step();
    // W2: sel=7 qual=1 pri=00011
    sel = 3'd7; qual = 1'b1; pri = 5'b00011;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++;
      if ({in_ready, out_valid, dec} !== {1'b0, 1'b1, 16'h0010}) begin
        n_fail++;
        $display("FAIL bp_stall_c%0d: got rdy=%b ov=%b dec=%h, expected 0 1 0010",
                 c + 2, in_ready, out_valid, dec);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if ({in_ready, dec, pri_hit} !== {1'b1, 16'h0010, 5'b00000}) begin
      n_fail++;
      $display("FAIL bp_w0_held: got rdy=%b dec=%h ph=%b, expected 1 0010 00000",
               in_ready, dec, pri_hit);
    end
    step();
    in_valid = 1'b0;
    n_tests++;
    if ({out_valid, dec, pri_hit, any_hit} !== {1'b1, 16'h0001, 5'b00100, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_w1: got ov=%b dec=%h ph=%b any=%b, expected 1 0001 00100 1",
               out_valid, dec, pri_hit, any_hit);
    end
    step();
    n_tests++;
    if ({out_valid, dec, pri_hit, any_hit} !== {1'b1, 16'h8000, 5'b00000, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_w2: got ov=%b dec=%h ph=%b any=%b, expected 1 8000 00000 0",
               out_valid, dec, pri_hit, any_hit);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got ov=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; sel = 3'd0; qual = 1'(i & 1); pri = 5'b00000;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    step();
    n_tests++;
    if ({s_none_cnt, none_cnt} !== {2'd3, 8'd5}) begin
      n_fail++;
      $display("FAIL sat_count: got sat=%0d wide=%0d, expected sat=3 wide=5", s_none_cnt, none_cnt);
    end
    in_valid = 1'b1; sel = 3'd0; qual = 1'b0; pri = 5'b00000;
    step();
    in_valid = 1'b0;
    step();
    n_tests++;
    if ({out_valid, none} !== 2'b11) begin
      n_fail++;
      $display("FAIL sat_pending_none: got ov=%b none=%b, expected 1 1", out_valid, none);
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_tests++;
    if ({s_none_cnt, none_cnt} !== {2'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL sat_clr_wins: got sat=%0d wide=%0d, expected 0 0", s_none_cnt, none_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; sel = 3'd0; qual = 1'b1; pri = 5'b00000;
      step();
    end
    n_tests++;
    if ({out_valid, none_cnt} !== {1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL midrst_before: got ov=%b cnt=%0d, expected 1 1", out_valid, none_cnt);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, none_cnt, dec} !== {1'b0, 8'd0, 16'h0}) begin
      n_fail++;
      $display("FAIL midrst_async: got ov=%b cnt=%0d dec=%h, expected 0 0 0000",
               out_valid, none_cnt, dec);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_tests++;
      if ({out_valid, dec, none_cnt} !== {1'b0, 16'h0, 8'd0}) begin
        n_fail++;
        $display("FAIL midrst_stale_c%0d: got ov=%b dec=%h cnt=%0d, expected 0 0000 0",
                 c, out_valid, dec, none_cnt);
      end
    end
  endtask

  task automatic test_idle_toggle();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; sel = 3'd3; qual = 1'b1; pri = 5'b10010;
    step();
    in_valid = 1'b0;
    step();
    step();
    for (int c = 0; c < 20; c++) begin
      sel       = 3'($urandom_range(0, 7));
      qual      = 1'($urandom_range(0, 1));
      pri       = 5'($urandom_range(0, 31));
      out_ready = 1'($urandom_range(0, 1));
      step();
      n_tests++;
      if ({dut.s1_sel_q, dut.s1_qual_q, dut.s1_pri_q, dec, pri_hit, none, any_hit,
           out_valid, none_cnt, in_ready} !==
          {3'd3, 1'b1, 5'b10010, 16'h0080, 5'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
        n_fail++;
        $display("FAIL idle_c%0d: got s1=%0d/%b/%b dec=%h ph=%b none=%b any=%b ov=%b cnt=%0d rdy=%b, expected 3/1/10010 0080 0 0 0 0 0 1",
                 c, dut.s1_sel_q, dut.s1_qual_q, dut.s1_pri_q, dec, pri_hit, none, any_hit,
                 out_valid, none_cnt, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_saturation();
    test_mid_reset();
    test_idle_toggle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
